// File: rtl/tipi_rpi_link_if.sv
// RPi-side serial lines of the TIPI link.
// The master is the RPi and the slave is the FPGA link stage.
interface tipi_rpi_link_if;
    logic r_clk;
    logic r_le;
    logic r_rt;
    logic r_cd;
    logic r_dout;
    logic r_din;

    modport master (output r_clk, r_le, r_rt, r_cd, r_dout, input r_din);
    modport slave  (input r_clk, r_le, r_rt, r_cd, r_dout, output r_din);
endinterface

// File: rtl/tipi_rpi_link.sv
// TIPI RPi serial link stage. The RPi strobes are synchronised into clk, and the
// TD/TC/RD/RC channels are shifted and latched using those synchronised edges.
module tipi_rpi_link #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned BITS        = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    tipi_rpi_link_if.slave    rpi,
    input  logic [0:7]        td_in,
    input  logic [0:7]        tc_in,
    output logic [0:7]        rd_out,
    output logic [0:7]        rc_out,
    output logic              rd_strobe,
    output logic              rc_strobe,
    output logic              frame_err,
    input  logic              err_clr
);

    localparam int unsigned CW  = 4;
    localparam int unsigned NIN = 5;
    localparam logic [CW-1:0] CNT_FULL = CW'(BITS);
    localparam logic [CW-1:0] CNT_SAT  = CW'(BITS + 1);

    // Channel index is {rt, cd}: 0 = RC, 1 = RD, 2 = TC, 3 = TD.
    localparam logic [1:0] CH_RC = 2'd0;
    localparam logic [1:0] CH_RD = 2'd1;
    localparam logic [1:0] CH_TD = 2'd3;

    logic [SYNC_STAGES-1:0][NIN-1:0] sync_q;
    logic [NIN-1:0]                  raw;
    logic [NIN-1:0]                  s;
    logic                            clk_prev;
    logic                            le_prev;
    logic                            clk_rise;
    logic                            le_rise;
    logic [1:0]                      sel;
    logic                            dout_s;
    logic                            err_set;

    logic [3:0][0:7]                 sr;
    logic [3:0][CW-1:0]              cnt;

    assign raw      = {rpi.r_clk, rpi.r_le, rpi.r_rt, rpi.r_cd, rpi.r_dout};
    assign s        = sync_q[SYNC_STAGES-1];
    assign sel      = s[2:1];
    assign dout_s   = s[0];
    assign clk_rise = s[4] & ~clk_prev;
    assign le_rise  = s[3] & ~le_prev;
    assign err_set  = le_rise & ~sel[1] & (cnt[sel] != CNT_FULL);

    // Synchroniser chain plus one edge-detect flop per strobe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q   <= '0;
            clk_prev <= 1'b0;
            le_prev  <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], raw};
            clk_prev <= s[4];
            le_prev  <= s[3];
        end
    end

    // Only the selected channel moves. A latch edge takes priority over a shift edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sr        <= '0;
            cnt       <= '0;
            rd_out    <= '0;
            rc_out    <= '0;
            rd_strobe <= 1'b0;
            rc_strobe <= 1'b0;
        end else begin
            rd_strobe <= 1'b0;
            rc_strobe <= 1'b0;
            if (le_rise) begin
                cnt[sel] <= '0;
                if (sel[1]) begin
                    sr[sel] <= (sel == CH_TD) ? td_in : tc_in;
                end else if (sel == CH_RD) begin
                    rd_out    <= sr[CH_RD];
                    rd_strobe <= 1'b1;
                end else begin
                    rc_out    <= sr[CH_RC];
                    rc_strobe <= 1'b1;
                end
            end else if (clk_rise) begin
                sr[sel] <= {sr[sel][1:7], sel[1] ? 1'b0 : dout_s};
                if (cnt[sel] != CNT_SAT) begin
                    cnt[sel] <= cnt[sel] + CW'(1);
                end
            end
        end
    end

    // Sticky framing error. A new error in the same clk as err_clr keeps the flag set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_err <= 1'b0;
        end else if (err_set) begin
            frame_err <= 1'b1;
        end else if (err_clr) begin
            frame_err <= 1'b0;
        end
    end

    // Return path: the TI channels send their MSB, the RPi channels send their parity.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rpi.r_din <= 1'b0;
        end else begin
            unique case (sel)
                2'd3:    rpi.r_din <= sr[3][0];
                2'd2:    rpi.r_din <= sr[2][0];
                2'd1:    rpi.r_din <= ^sr[1];
                default: rpi.r_din <= ^sr[0];
            endcase
        end
    end

endmodule
